// File: rtl/mini_mips_fetch_pkg.sv
// Shared types and constants for the mini MIPS instruction prefetch stage.
package mini_mips_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] PC_INC = 32'd1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/mini_mips_fetch_fifo.sv
// Small synchronous FIFO with flush, used to buffer fetched instructions.
module mini_mips_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (!(push_i && full && !pop_i));
      assert (!(pop_i && empty_o));
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // NOTE: storage is not reset; entries are only observed through count/pointers, which are.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mini_mips_fetch.sv
// Instruction prefetch stage: credit-limited issue, in-order response buffering, redirect flush.
// Optional stall counter port enabled by defining MINI_MIPS_FETCH_STATS_EN.
module mini_mips_fetch
  import mini_mips_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef MINI_MIPS_FETCH_STATS_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            credit_ok, accept, keep, pop;
  fetch_entry_t    head, wentry;

  // Credits cover both buffered and in-flight words, so the FIFO can never overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outst_q}) < SW'(DEPTH);
  assign imem_req  = !reset && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;
  assign keep      = imem_rvalid && (drop_q == '0) && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;
  assign wentry    = '{instr: imem_rdata, pc: resp_pc_q};

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? '0 : head.instr;
  assign out_pc    = fifo_empty ? '0 : head.pc;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = outst_q - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_INC;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (keep) resp_pc_d = resp_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  mini_mips_fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (keep),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .wdata_i(wentry),
    .rdata_o(head),
    .count_o(fifo_count),
    .empty_o(fifo_empty)
  );

`ifdef MINI_MIPS_FETCH_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_ready && !out_valid && !redirect_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mini_mips_fetch.sv
// Directed bench for mini_mips_fetch with an in-order fixed-latency memory model.
module tb_mini_mips_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef MINI_MIPS_FETCH_STATS_EN
  logic [31:0] stall_count;
`endif

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;

  req_t mem_q[$];
  int   cyc      = 0;
  int   lat      = 1;
  int   accepts  = 0;
  int   checks   = 0;
  int   errors   = 0;

  mini_mips_fetch #(
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef MINI_MIPS_FETCH_STATS_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Closes the current cycle: logs an accepted request, crosses the edge, then
  // drives the memory response due in the new cycle. Returns at negedge + 1.
  task automatic tick();
    req_t r;
    #1;
    if (imem_req && imem_ready) begin
      mem_q.push_back('{due: cyc + lat, addr: imem_addr});
      accepts++;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = r.addr[15:0];
    end
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_q.delete();
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
`ifdef MINI_MIPS_FETCH_STATS_EN
    chk("rst_stall_count", stall_count, 32'd0);
`endif
    tick();
    tick();
    reset   = 1'b0;
    cyc     = 0;
    accepts = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming with a 1-cycle memory and an always-ready core.
    lat = 1;
    reset = 1'b1;
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stream_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream_pc[%0d]", k), out_pc, 32'(k));
      chk($sformatf("stream_instr[%0d]", k), {16'd0, out_instr}, 32'(k));
      tick();
    end

    // Reset mid-stream, then backpressure fills the credit window.
    do_reset();
    repeat (10) tick();
    chk("bp_accepts", 32'(accepts), 32'd4);
    chk("bp_req_low", {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pc_held", out_pc, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_release_valid[%0d]", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_release_pc[%0d]", k), out_pc, 32'(k));
      tick();
    end

    // 3-cycle memory: redirect with three requests in flight, one returning now.
    lat = 3;
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("lat3_empty_before", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("lat3_redirect_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("lat3_target_req", {31'd0, imem_req}, 32'd1);
    chk("lat3_target_addr", imem_addr, 32'h40);
    chk("lat3_no_stale_c4", {31'd0, out_valid}, 32'd0);
    for (int k = 5; k < 8; k++) begin
      tick();
      chk($sformatf("lat3_no_stale_c%0d", k), {31'd0, out_valid}, 32'd0);
    end
    tick();
    chk("lat3_valid", {31'd0, out_valid}, 32'd1);
    chk("lat3_pc", out_pc, 32'h40);
    chk("lat3_instr", {16'd0, out_instr}, 32'h40);
    tick();
    chk("lat3_pc_next", out_pc, 32'h41);

    // Redirect coinciding with a response and an output handshake.
    lat = 1;
    do_reset();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("coinc_valid", {31'd0, out_valid}, 32'd1);
    chk("coinc_pc", out_pc, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("coinc_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_flushed", {31'd0, out_valid}, 32'd0);
    chk("coinc_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_addr", imem_addr, 32'h100);
    tick();
    chk("coinc_empty2", {31'd0, out_valid}, 32'd0);
    tick();
    chk("coinc_target_valid", {31'd0, out_valid}, 32'd1);
    chk("coinc_target_pc", out_pc, 32'h100);
    chk("coinc_target_instr", {16'd0, out_instr}, 32'h100);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFF);
    tick();
    chk("wrap_addr_zero", imem_addr, 32'h0);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("wrap_out_pc_top", out_pc, 32'hFFFF_FFFF);
    chk("wrap_out_instr_top", {16'd0, out_instr}, 32'h0000_FFFF);
    tick();
    chk("wrap_out_valid_zero", {31'd0, out_valid}, 32'd1);
    chk("wrap_out_pc_zero", out_pc, 32'h0);
    chk("wrap_out_instr_zero", {16'd0, out_instr}, 32'h0);

`ifdef MINI_MIPS_FETCH_STATS_EN
    // Ready core, idle memory: every cycle is a stall.
    do_reset();
    out_ready  = 1'b1;
    imem_ready = 1'b0;
    repeat (5) tick();
    chk("stall_count_5", stall_count, 32'd5);
    imem_ready = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
